// File: rtl/oc_dummy_runner_pkg.sv
// Shared definitions for the dummy-logic run controller.
// Holds the FSM state encoding and the register-block id used by a future CSR wrapper.
package oc_dummy_runner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dummy_runner_state_e;

    localparam logic [15:0] CsrIdDummyRunner = 16'h0d52;

endpackage

// File: rtl/oclib_dummy_accum.sv
// One dummy-datapath channel: run-token delay line, stimulus counter and output accumulator.
// The token travels ControlPipeStages to the stimulus register, then DatapathLatency more to the accumulator.
module oclib_dummy_accum #(
    parameter int Index             = 0,
    parameter int DatapathWidth     = 32,
    parameter int DatapathLatency   = 8,
    parameter int ControlPipeStages = 5,
    parameter int SumWidth          = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     run,
    input  logic                     chan_en,
    input  logic [DatapathWidth-1:0] dummy_out,
    output logic [DatapathWidth-1:0] dummy_in,
    output logic [SumWidth-1:0]      sum
);

    localparam int TokDepth = ControlPipeStages + DatapathLatency;

    logic                     en_q;
    logic                     tok_in;
    logic [TokDepth:0]        tok_all;
    logic [DatapathWidth-1:0] stim_k;

    // Plain flops so the placer can spread the fanout instead of packing into shift-register primitives.
    (* dont_touch = "true" *) logic [TokDepth:1] tok_q;

    assign tok_in  = run && en_q;
    assign tok_all = {tok_q, tok_in};

    always_ff @(posedge clock) begin
        if (reset) begin
            tok_q    <= '0;
            en_q     <= 1'b0;
            stim_k   <= '0;
            dummy_in <= '0;
            sum      <= '0;
        end else begin
            tok_q <= tok_all[TokDepth-1:0];
            if (start) begin
                en_q   <= chan_en;
                stim_k <= '0;
                sum    <= '0;
                if (!chan_en) begin
                    dummy_in <= DatapathWidth'(Index);
                end
            end else begin
                // Stimulus register is the last control stage; the token lands on it together with its value.
                if (tok_all[ControlPipeStages-1]) begin
                    dummy_in <= DatapathWidth'(Index) + stim_k;
                    stim_k   <= stim_k + DatapathWidth'(1);
                end
                if (tok_all[TokDepth]) begin
                    sum <= sum + SumWidth'(dummy_out);
                end
            end
        end
    end

endmodule

// File: rtl/oc_dummy_runner.sv
// Run controller for dummy-logic timing tests: sequences runs in prescaled chunks and
// collects per-channel sums, which stay frozen after the run until the next one starts.
//
// state | meaning
// IDLE  | waiting for go; results from the last run still visible
// RUN   | tokens issued every cycle to enabled channels, prescale/chunk counting
// DRAIN | no new tokens; in-flight samples still being accumulated
// DONE  | results and sigPass stable; go=0 returns to IDLE
module oc_dummy_runner
    import oc_dummy_runner_pkg::*;
#(
    parameter int DatapathCount     = 4,
    parameter int DatapathWidth     = 32,
    parameter int DatapathLatency   = 8,
    parameter int ControlPipeStages = 5,
    parameter int PrescaleBits      = 16,
    parameter int ChunkBits         = 32,
    parameter int SumWidth          = 32
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   go,
    input  logic                                   continuous,
    input  logic [ChunkBits-1:0]                   testChunks,
    input  logic [DatapathCount-1:0]               channelEnable,
    input  logic [SumWidth-1:0]                    expectedSig,
    output logic [DatapathCount*DatapathWidth-1:0] dummyIn,
    input  logic [DatapathCount*DatapathWidth-1:0] dummyOut,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   aborted,
    output logic                                   sigPass,
    output logic [ChunkBits-1:0]                   chunk,
    output logic [DatapathCount*SumWidth-1:0]      dummySum
);

    localparam int DrainCycles = ControlPipeStages + DatapathLatency;
    localparam int DrainBits   = $clog2(DrainCycles + 1);

    dummy_runner_state_e     state, state_next;
    logic [PrescaleBits-1:0] prescale;
    logic [ChunkBits-1:0]    chunk_q;
    logic [ChunkBits-1:0]    last_chunk;
    logic                    cont_q;
    logic                    aborted_q;
    logic                    sig_pass_q;
    logic [DrainBits-1:0]    drain_cnt;
    logic [SumWidth-1:0]     sig_xor;
    logic                    start;
    logic                    run;
    logic                    fixed_done;
    logic                    run_exit;
    logic                    drain_end;

    assign start      = (state == IDLE) && go;
    assign run        = (state == RUN);
    assign fixed_done = run && !cont_q && (prescale == '1) && (chunk_q == last_chunk);
    assign run_exit   = run && (fixed_done || !go);
    assign drain_end  = (state == DRAIN) && (drain_cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (go)         state_next = RUN;
            RUN:     if (run_exit)   state_next = DRAIN;
            DRAIN:   if (drain_end)  state_next = DONE;
            DONE:    if (!go)        state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale   <= '0;
            chunk_q    <= '0;
            last_chunk <= '0;
            cont_q     <= 1'b0;
            aborted_q  <= 1'b0;
            sig_pass_q <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            if (start) begin
                cont_q     <= continuous;
                last_chunk <= (testChunks == '0) ? '0 : testChunks - ChunkBits'(1);
                prescale   <= '0;
                chunk_q    <= '0;
                aborted_q  <= 1'b0;
                sig_pass_q <= 1'b0;
            end
            if (run) begin
                prescale <= prescale + PrescaleBits'(1);
                if ((prescale == '1) && (chunk_q != '1)) begin
                    chunk_q <= chunk_q + ChunkBits'(1);
                end
            end
            // Early go drop only counts as an abort when the run had a defined length.
            if (run_exit) begin
                drain_cnt <= DrainBits'(DrainCycles);
                if (!fixed_done && !cont_q) begin
                    aborted_q <= 1'b1;
                end
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DrainBits'(1);
            end
            if (drain_end) begin
                sig_pass_q <= (sig_xor == expectedSig);
            end
        end
    end

    always_comb begin
        sig_xor = '0;
        for (int i = 0; i < DatapathCount; i++) begin
            sig_xor = sig_xor ^ dummySum[i*SumWidth +: SumWidth];
        end
    end

    for (genvar i = 0; i < DatapathCount; i++) begin : g_chan
        oclib_dummy_accum #(
            .Index             (i),
            .DatapathWidth     (DatapathWidth),
            .DatapathLatency   (DatapathLatency),
            .ControlPipeStages (ControlPipeStages),
            .SumWidth          (SumWidth)
        ) u_accum (
            .clock     (clock),
            .reset     (reset),
            .start     (start),
            .run       (run),
            .chan_en   (channelEnable[i]),
            .dummy_out (dummyOut[i*DatapathWidth +: DatapathWidth]),
            .dummy_in  (dummyIn[i*DatapathWidth +: DatapathWidth]),
            .sum       (dummySum[i*SumWidth +: SumWidth])
        );
    end

    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign aborted = aborted_q;
    assign sigPass = sig_pass_q;
    assign chunk   = chunk_q;

endmodule

// File: tb/tb_oc_dummy_runner.sv
// Directed bench for oc_dummy_runner with two channels, each modelled as a 3-register identity pipeline.
module tb_oc_dummy_runner;

    logic        clock = 1'b0;
    logic        reset;
    logic        go;
    logic        continuous;
    logic [31:0] testChunks;
    logic [1:0]  channelEnable;
    logic [31:0] expectedSig;
    logic [63:0] dummyIn;
    logic [63:0] dummyOut;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        sigPass;
    logic [31:0] chunk;
    logic [63:0] dummySum;

    logic [63:0] pipe_a = '0;
    logic [63:0] pipe_b = '0;
    logic [63:0] pipe_c = '0;

    int checks   = 0;
    int failures = 0;
    int bcnt;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        pipe_a <= dummyIn;
        pipe_b <= pipe_a;
        pipe_c <= pipe_b;
    end
    assign dummyOut = pipe_c;

    oc_dummy_runner #(
        .DatapathCount     (2),
        .DatapathWidth     (32),
        .DatapathLatency   (3),
        .ControlPipeStages (2),
        .PrescaleBits      (4),
        .ChunkBits         (32),
        .SumWidth          (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .go            (go),
        .continuous    (continuous),
        .testChunks    (testChunks),
        .channelEnable (channelEnable),
        .expectedSig   (expectedSig),
        .dummyIn       (dummyIn),
        .dummyOut      (dummyOut),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .sigPass       (sigPass),
        .chunk         (chunk),
        .dummySum      (dummySum)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] tc, input logic [1:0] en, input logic cont,
                             input logic [31:0] sig);
        @(negedge clock);
        testChunks    = tc;
        channelEnable = en;
        continuous    = cont;
        expectedSig   = sig;
        go            = 1'b1;
    endtask

    // Counts busy cycles until done; optionally drops go after drop_after RUN cycles
    // and raises it again in the first DRAIN cycle.
    task automatic wait_done(input int drop_after, input bit regrab, output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        for (int n = 0; n < 4000 && !seen; n++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
            end else if (busy) begin
                cnt++;
                if (drop_after != 0 && cnt == drop_after) go = 1'b0;
                else if (regrab && drop_after != 0 && cnt == drop_after + 1) go = 1'b1;
            end
        end
        check_val("done_reached", {63'd0, seen}, 64'd1);
    endtask

    task automatic finish_run(input logic [31:0] sum0_hold);
        @(negedge clock);
        go = 1'b0;
        @(negedge clock);
        check_val("idle_after_done", {63'd0, done}, 64'd0);
        check_val("sum0_held_idle", {32'd0, dummySum[31:0]}, {32'd0, sum0_hold});
    endtask

    initial begin
        reset         = 1'b1;
        go            = 1'b0;
        continuous    = 1'b0;
        testChunks    = '0;
        channelEnable = '0;
        expectedSig   = '0;
        repeat (3) @(negedge clock);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_chunk", {32'd0, chunk}, 64'd0);
        check_val("rst_sums", dummySum, 64'd0);
        check_val("rst_dummy_in", dummyIn, 64'd0);
        check_val("rst_aborted", {63'd0, aborted}, 64'd0);
        check_val("rst_sigpass", {63'd0, sigPass}, 64'd0);
        reset = 1'b0;

        // fixed run, two chunks
        start_run(32'd2, 2'b11, 1'b0, 32'd496 ^ 32'd528);
        wait_done(0, 1'b0, bcnt);
        check_val("t1_busy_cycles", 64'(bcnt), 64'd38);
        check_val("t1_chunk", {32'd0, chunk}, 64'd2);
        check_val("t1_sum0", {32'd0, dummySum[31:0]}, 64'd496);
        check_val("t1_sum1", {32'd0, dummySum[63:32]}, 64'd528);
        check_val("t1_sigpass", {63'd0, sigPass}, 64'd1);
        check_val("t1_aborted", {63'd0, aborted}, 64'd0);
        repeat (3) @(negedge clock);
        check_val("t1_done_held", {63'd0, done}, 64'd1);
        check_val("t1_no_restart", {63'd0, busy}, 64'd0);
        finish_run(32'd496);

        // channel 0 masked
        start_run(32'd1, 2'b10, 1'b0, 32'd136);
        wait_done(0, 1'b0, bcnt);
        check_val("t2_busy_cycles", 64'(bcnt), 64'd22);
        check_val("t2_sum0", {32'd0, dummySum[31:0]}, 64'd0);
        check_val("t2_dummy_in0", {32'd0, dummyIn[31:0]}, 64'd0);
        check_val("t2_dummy_in1", {32'd0, dummyIn[63:32]}, 64'd16);
        check_val("t2_sum1", {32'd0, dummySum[63:32]}, 64'd136);
        check_val("t2_sigpass", {63'd0, sigPass}, 64'd1);
        finish_run(32'd0);

        // abort after 20 RUN cycles, go raised again during DRAIN
        start_run(32'd4, 2'b11, 1'b0, 32'd0);
        wait_done(20, 1'b1, bcnt);
        check_val("t3_busy_cycles", 64'(bcnt), 64'd26);
        check_val("t3_aborted", {63'd0, aborted}, 64'd1);
        check_val("t3_sum0", {32'd0, dummySum[31:0]}, 64'd190);
        check_val("t3_sum1", {32'd0, dummySum[63:32]}, 64'd210);
        check_val("t3_chunk", {32'd0, chunk}, 64'd1);
        check_val("t3_sigpass", {63'd0, sigPass}, 64'd0);
        finish_run(32'd190);

        // continuous, 100 RUN cycles
        start_run(32'd1, 2'b11, 1'b1, 32'd4950 ^ 32'd5050);
        wait_done(100, 1'b0, bcnt);
        check_val("t4_busy_cycles", 64'(bcnt), 64'd106);
        check_val("t4_chunk", {32'd0, chunk}, 64'd6);
        check_val("t4_sum0", {32'd0, dummySum[31:0]}, 64'd4950);
        check_val("t4_sum1", {32'd0, dummySum[63:32]}, 64'd5050);
        check_val("t4_aborted", {63'd0, aborted}, 64'd0);
        check_val("t4_sigpass", {63'd0, sigPass}, 64'd1);
        finish_run(32'd4950);

        // reset mid-run, then a fresh run with go still high
        start_run(32'd2, 2'b11, 1'b0, 32'd496 ^ 32'd528);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("t5_busy", {63'd0, busy}, 64'd0);
        check_val("t5_chunk", {32'd0, chunk}, 64'd0);
        check_val("t5_sums", dummySum, 64'd0);
        check_val("t5_dummy_in", dummyIn, 64'd0);
        reset = 1'b0;
        wait_done(0, 1'b0, bcnt);
        check_val("t5_busy_cycles", 64'(bcnt), 64'd38);
        check_val("t5_chunk_end", {32'd0, chunk}, 64'd2);
        check_val("t5_sum0", {32'd0, dummySum[31:0]}, 64'd496);
        check_val("t5_sum1", {32'd0, dummySum[63:32]}, 64'd528);
        check_val("t5_sigpass", {63'd0, sigPass}, 64'd1);
        finish_run(32'd496);

        // testChunks=0 acts as 1; wrong signature; go held in DONE
        start_run(32'd0, 2'b11, 1'b0, 32'hdead_beef);
        wait_done(0, 1'b0, bcnt);
        check_val("t6_busy_cycles", 64'(bcnt), 64'd22);
        check_val("t6_chunk", {32'd0, chunk}, 64'd1);
        check_val("t6_sum0", {32'd0, dummySum[31:0]}, 64'd120);
        check_val("t6_sum1", {32'd0, dummySum[63:32]}, 64'd136);
        check_val("t6_sigpass", {63'd0, sigPass}, 64'd0);
        repeat (4) @(negedge clock);
        check_val("t6_done_held", {63'd0, done}, 64'd1);
        check_val("t6_no_restart", {63'd0, busy}, 64'd0);
        finish_run(32'd120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
